// File: rtl/max_scan_mem.sv
// max_scan_mem
//   Word-organised data memory for the single-cycle MIPS core, plus a scan
//   engine that walks a fixed window of SCAN_LEN words starting at word
//   SCAN_BASE (wrapping modulo DEPTH) and reports the largest element and its
//   zero-based index within the window.
//
// Ports
//   clock        sole clock, rising edge
//   rst          synchronous active-high reset (memory array is not cleared)
//   address      byte address from the ALU; word = address[log2(DEPTH)+1:2]
//   write_data   store data from register-file read port 2
//   mem_read     load enable; read_data is 0 when low
//   mem_write    store enable
//   read_data    combinational load data
//   scan_start   scan request, only honoured in IDLE
//   scan_busy    high while in SCAN
//   scan_done    one-cycle pulse in DONE, result valid
//   max          largest element of the last completed scan
//   max_index    index of max within the window, zero-extended
//
// Build option
//   MAXSCAN_SIGNED_EN defined   : signed two's complement comparison
//   MAXSCAN_SIGNED_EN undefined : unsigned comparison (default)
//
// state | meaning
// IDLE  | waiting for scan_start; element 0 is presented to the comparator
// SCAN  | element ptr compared against the running maximum each cycle
// DONE  | result registered, scan_done high for this single cycle
module max_scan_mem #(
    parameter int DEPTH     = 256,
    parameter int SCAN_BASE = 250,
    parameter int SCAN_LEN  = 20
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] read_data,
    input  logic        scan_start,
    output logic        scan_busy,
    output logic        scan_done,
    output logic [31:0] max,
    output logic [31:0] max_index
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LAST_PTR = 32'(SCAN_LEN - 1);
    localparam logic [31:0] BASE_W   = 32'(SCAN_BASE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic [31:0]   max_q;
    logic [31:0]   max_idx_q;
    logic [31:0]   cur_max_q;
    logic [31:0]   cur_max_d;
    logic [31:0]   cur_idx_q;
    logic [31:0]   cur_idx_d;
    logic [31:0]   ptr_q;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] addr_word;
    logic [31:0]   elem_ptr;
    logic [31:0]   elem_sum;
    logic [AW-1:0] scan_word;
    logic [31:0]   elem_val;
    logic          elem_gt;

    // ------------------------------------------------------------------
    // Load / store port
    // ------------------------------------------------------------------
    assign addr_word = address[AW+1:2];
    assign read_data = mem_read ? mem[addr_word] : 32'd0;

    always_ff @(posedge clock) begin
        if (mem_write) begin
            mem[addr_word] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Scan element fetch and compare
    // ------------------------------------------------------------------
    // Outside SCAN the comparator looks at element 0 so the IDLE->SCAN edge
    // can seed the running maximum without an extra cycle.
    assign elem_ptr  = (state_q == S_SCAN) ? ptr_q : 32'd0;
    assign elem_sum  = BASE_W + elem_ptr;
    // DEPTH is a power of two, so the low bits give the wrap modulo DEPTH.
    assign scan_word = elem_sum[AW-1:0];
    assign elem_val  = mem[scan_word];

`ifdef MAXSCAN_SIGNED_EN
    assign elem_gt = $signed(elem_val) > $signed(cur_max_q);
`else
    assign elem_gt = elem_val > cur_max_q;
`endif

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        cur_max_d = cur_max_q;
        cur_idx_d = cur_idx_q;
        if (elem_gt) begin
            cur_max_d = elem_val;
            cur_idx_d = ptr_q;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{address[31:AW+2], address[1:0], elem_sum[31:AW]};

    // ------------------------------------------------------------------
    // Scan FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            max_q     <= 32'd0;
            max_idx_q <= 32'd0;
            cur_max_q <= 32'd0;
            cur_idx_q <= 32'd0;
            ptr_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (scan_start) begin
                        if (SCAN_LEN == 1) begin
                            max_q     <= elem_val;
                            max_idx_q <= 32'd0;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            cur_max_q <= elem_val;
                            cur_idx_q <= 32'd0;
                            ptr_q     <= 32'd1;
                            busy_q    <= 1'b1;
                            state_q   <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    cur_max_q <= cur_max_d;
                    cur_idx_q <= cur_idx_d;
                    ptr_q     <= ptr_q + 32'd1;
                    if (ptr_q == LAST_PTR) begin
                        max_q     <= cur_max_d;
                        max_idx_q <= cur_idx_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign scan_busy = busy_q;
    assign scan_done = done_q;
    assign max       = max_q;
    assign max_index = max_idx_q;

endmodule

// File: tb/tb_max_scan_mem.sv
module tb_max_scan_mem;

    localparam int DEPTH = 256;
    localparam int BASE  = 250;
    localparam int L     = 20;

    logic        clock = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] read_data;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [31:0] dut_max;
    logic [31:0] dut_max_index;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [DEPTH];

    max_scan_mem #(.DEPTH(DEPTH), .SCAN_BASE(BASE), .SCAN_LEN(L)) dut (
        .clock      (clock),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_done  (scan_done),
        .max        (dut_max),
        .max_index  (dut_max_index)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int word_of(input int elem);
        return (BASE + elem) % DEPTH;
    endfunction

    function automatic bit ref_gt(input logic [31:0] a, input logic [31:0] b);
`ifdef MAXSCAN_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Element i is compared in cycle i; a store in cycle c is seen only by
    // comparisons in later cycles.
    task automatic ref_scan(input int st_cycle, input int st_elem, input logic [31:0] st_data,
                            output logic [31:0] mx, output logic [31:0] mi);
        logic [31:0] v;
        mx = model_mem[word_of(0)];
        if (st_cycle >= 0 && st_elem == 0 && 0 > st_cycle) mx = st_data;
        mi = 0;
        for (int i = 1; i < L; i++) begin
            v = model_mem[word_of(i)];
            if (st_cycle >= 0 && st_elem == i && i > st_cycle) v = st_data;
            if (ref_gt(v, mx)) begin
                mx = v;
                mi = 32'(i);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic write_addr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        address    = addr;
        write_data = data;
        mem_write  = 1'b1;
        @(posedge clock);
        #1;
        mem_write  = 1'b0;
        model_mem[addr[9:2]] = data;
    endtask

    task automatic write_elem(input int elem, input logic [31:0] data);
        write_addr(32'(word_of(elem) * 4 + $urandom_range(0, 3)), data);
    endtask

    task automatic do_scan(input int ncyc, input int hold,
                           input int st_cycle, input int st_elem, input logic [31:0] st_data,
                           output int busy_cnt, output int first_busy, output int last_busy,
                           output int done_cnt, output int done_cyc, output int done_cyc2,
                           output logic [31:0] mx, output logic [31:0] mi);
        busy_cnt = 0; first_busy = -1; last_busy = -1;
        done_cnt = 0; done_cyc = -1; done_cyc2 = -1;
        mx = '0; mi = '0;
        @(negedge clock);
        scan_start = 1'b1;
        address    = 32'(word_of(st_elem) * 4);
        write_data = st_data;
        mem_write  = (st_cycle == 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            if (scan_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (scan_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    mx = dut_max;
                    mi = dut_max_index;
                end else if (done_cyc2 < 0) begin
                    done_cyc2 = c;
                end
            end
            scan_start = (c < hold);
            mem_write  = (c == st_cycle);
        end
        scan_start = 1'b0;
        mem_write  = 1'b0;
        if (st_cycle >= 0 && st_cycle <= ncyc) model_mem[word_of(st_elem)] = st_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; scan_start = 0; mem_read = 0; mem_write = 0;
        address = 0; write_data = 0;
        repeat (3) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        n_checks++;
        if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b, required 0 0", scan_busy, scan_done);
        end
        n_checks++;
        if (dut_max !== 32'd0 || dut_max_index !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result: max=%h idx=%0d, required 0 0", dut_max, dut_max_index);
        end
        n_checks++;
        if (read_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_read_disabled: read_data=%h, required 0", read_data);
        end
    endtask

    task automatic test_store_load();
        write_addr(32'h10, 32'hDEADBEEF);
        @(negedge clock);
        mem_read = 1'b1;
        address  = 32'h10;
        #1;
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_0x10: read_data=%h, required deadbeef", read_data);
        end
        address = 32'h13;
        #1;
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_0x13: read_data=%h, required deadbeef", read_data);
        end
        address = 32'h410;
        #1;
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_upper_bits_ignored: read_data=%h, required deadbeef", read_data);
        end
        mem_read = 1'b0;
        #1;
        n_checks++;
        if (read_data !== 32'd0) begin
            n_fail++;
            $display("FAIL load_disabled: read_data=%h, required 0", read_data);
        end
        // store and load in the same cycle return the old word
        address    = 32'h10;
        write_data = 32'h12345678;
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        #1;
        n_checks++;
        if (read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL store_load_same_cycle: read_data=%h, required deadbeef", read_data);
        end
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        model_mem[4] = 32'h12345678;
        n_checks++;
        if (read_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL store_visible_next_cycle: read_data=%h, required 12345678", read_data);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_basic_scan();
        int bc, fb, lb, dc, dcy, dcy2;
        logic [31:0] mx, mi, emx, emi;
        logic [31:0] vals [6] = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd1, 32'd0};
        for (int i = 0; i < L; i++) write_elem(i, (i < 6) ? vals[i] : 32'd0);
        ref_scan(-1, 0, 0, emx, emi);
        do_scan(L + 2, 1, -1, 0, 0, bc, fb, lb, dc, dcy, dcy2, mx, mi);
        n_checks++;
        if (bc != L - 1 || fb != 1 || lb != L - 1) begin
            n_fail++;
            $display("FAIL basic_busy: count=%0d first=%0d last=%0d, required %0d 1 %0d", bc, fb, lb, L - 1, L - 1);
        end
        n_checks++;
        if (dc != 1 || dcy != L) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d cycle=%0d, required 1 %0d", dc, dcy, L);
        end
        n_checks++;
        if (mx !== emx || mi !== emi || mx !== 32'd9 || mi !== 32'd1) begin
            n_fail++;
            $display("FAIL basic_result: max=%0d idx=%0d, required %0d %0d", mx, mi, emx, emi);
        end
        @(negedge clock);
        n_checks++;
        if (dut_max !== emx || dut_max_index !== emi || scan_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_held: max=%0d idx=%0d done=%b, required %0d %0d 0", dut_max, dut_max_index, scan_done, emx, emi);
        end
    endtask

    task automatic test_sign();
        int bc, fb, lb, dc, dcy, dcy2;
        logic [31:0] mx, mi, emx, emi, cmx, cmi;
        for (int i = 0; i < L; i++) write_elem(i, (i == 7) ? 32'hFFFFFFF0 : 32'd2);
        ref_scan(-1, 0, 0, emx, emi);
`ifdef MAXSCAN_SIGNED_EN
        cmx = 32'd2; cmi = 32'd0;
`else
        cmx = 32'hFFFFFFF0; cmi = 32'd7;
`endif
        do_scan(L + 1, 1, -1, 0, 0, bc, fb, lb, dc, dcy, dcy2, mx, mi);
        n_checks++;
        if (mx !== emx || mi !== emi || mx !== cmx || mi !== cmi || dcy != L) begin
            n_fail++;
            $display("FAIL sign_result: max=%h idx=%0d cycle=%0d, required %h %0d %0d", mx, mi, dcy, cmx, cmi, L);
        end
    endtask

    task automatic test_store_during_scan();
        int bc, fb, lb, dc, dcy, dcy2;
        logic [31:0] mx, mi, emx, emi;
        int cyc [4] = '{3, 2, 5, 1};
        for (int i = 0; i < L; i++) write_elem(i, 32'($urandom_range(0, 50)));
        for (int k = 0; k < 4; k++) begin
            write_elem(3, 32'd7);
            ref_scan(cyc[k], 3, 32'd100, emx, emi);
            do_scan(L + 1, 1, cyc[k], 3, 32'd100, bc, fb, lb, dc, dcy, dcy2, mx, mi);
            n_checks++;
            if (mx !== emx || mi !== emi || dcy != L) begin
                n_fail++;
                $display("FAIL store_during_scan_c%0d: max=%0d idx=%0d cycle=%0d, required %0d %0d %0d",
                         cyc[k], mx, mi, dcy, emx, emi, L);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int bc, fb, lb, dc, dcy, dcy2;
        logic [31:0] mx, mi, emx, emi;
        for (int i = 0; i < L; i++) write_elem(i, $urandom());
        @(negedge clock);
        scan_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            scan_start = 1'b0;
            if (c == 10) rst = 1'b1;
        end
        @(negedge clock);
        rst = 1'b0;
        n_checks++;
        if (scan_busy !== 1'b0 || scan_done !== 1'b0 || dut_max !== 32'd0 || dut_max_index !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_scan: busy=%b done=%b max=%h idx=%0d, required 0 0 0 0",
                     scan_busy, scan_done, dut_max, dut_max_index);
        end
        dc = 0;
        for (int c = 0; c < L; c++) begin
            @(negedge clock);
            if (scan_done || scan_busy) dc++;
        end
        n_checks++;
        if (dc != 0) begin
            n_fail++;
            $display("FAIL reset_mid_scan_quiet: activity_cycles=%0d, required 0", dc);
        end
        ref_scan(-1, 0, 0, emx, emi);
        do_scan(L + 1, 1, -1, 0, 0, bc, fb, lb, dc, dcy, dcy2, mx, mi);
        n_checks++;
        if (mx !== emx || mi !== emi || dcy != L || bc != L - 1) begin
            n_fail++;
            $display("FAIL reset_then_scan: max=%h idx=%0d cycle=%0d busy=%0d, required %h %0d %0d %0d",
                     mx, mi, dcy, bc, emx, emi, L, L - 1);
        end
    endtask

    task automatic test_ignored_start();
        int bc, fb, lb, dc, dcy, dcy2;
        logic [31:0] mx, mi, emx, emi;
        ref_scan(-1, 0, 0, emx, emi);
        do_scan(2 * L + 4, 25, -1, 0, 0, bc, fb, lb, dc, dcy, dcy2, mx, mi);
        n_checks++;
        if (dcy != L || dcy2 != 2 * L + 1 || dc != 2) begin
            n_fail++;
            $display("FAIL ignored_start: first=%0d second=%0d pulses=%0d, required %0d %0d 2",
                     dcy, dcy2, dc, L, 2 * L + 1);
        end
        n_checks++;
        if (bc != 2 * (L - 1) || mx !== emx || mi !== emi) begin
            n_fail++;
            $display("FAIL ignored_start_busy: busy=%0d max=%h idx=%0d, required %0d %h %0d",
                     bc, mx, mi, 2 * (L - 1), emx, emi);
        end
    endtask

    task automatic test_random_scans();
        int bc, fb, lb, dc, dcy, dcy2, stc, ste;
        logic [31:0] mx, mi, emx, emi, sd;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < L; i++)
                write_elem(i, (it % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom());
            stc = (it % 3 == 0) ? -1 : int'($urandom_range(0, L - 1));
            ste = int'($urandom_range(0, L - 1));
            sd  = $urandom();
            ref_scan(stc, ste, sd, emx, emi);
            do_scan(L + 1, 1, stc, ste, sd, bc, fb, lb, dc, dcy, dcy2, mx, mi);
            n_checks++;
            if (mx !== emx || mi !== emi || dcy != L || dc != 1) begin
                n_fail++;
                $display("FAIL random_scan_%0d: max=%h idx=%0d cycle=%0d, required %h %0d %0d",
                         it, mx, mi, dcy, emx, emi, L);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_basic_scan();
        test_sign();
        test_store_during_scan();
        test_reset_mid_scan();
        test_ignored_start();
        test_random_scans();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
